stream_ppfifo_packer: RTL and testbench

Upstream producer for the ping-pong FIFO write side. It accepts an 8-bit valid/ready byte stream and packs it little-endian into 32-bit words. It claims one of the two ping-pong buffers, fills it up to the advertised size, then releases it. Flush, end-of-packet or an idle timeout release a partially filled buffer early. It replaces the test data generator ahead of the PPFIFO that feeds the memory-writer DMA.

---
 rtl/stream_ppfifo_packer.sv | 166 ++++++++++++++++
 tb/tb_stream_ppfifo_packer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_ppfifo_packer.sv
// Packs an 8-bit valid/ready byte stream little-endian into 32-bit words for one
// ping-pong FIFO write buffer at a time. Define STREAM_PACKER_BYTE_COUNT_EN for o_byte_count.
module stream_ppfifo_packer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_flush,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  input  logic [1:0]  i_wr_rdy,
  output logic [1:0]  o_wr_act,
  input  logic [23:0] i_wr_size,
  output logic        o_wr_stb,
  output logic [31:0] o_wr_data,
  output logic        o_busy,
  output logic [31:0] o_byte_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PAD, S_RELEASE} state_t;

  state_t        state, state_next;
  logic [1:0]    byte_idx;
  logic [23:0]   partial;
  logic [23:0]   r_size;
  logic [23:0]   word_count;
  logic          r_full;
  logic          r_last_used;
  logic [TW-1:0] idle_cnt;

  logic       claim, claim_sel;
  logic       accept, word_done, full_hit;
  logic       pending, timeout, trigger;
  logic [1:0] idx_after;
  logic       words_after;

  assign o_ready   = (state == S_FILL) & ~r_full;
  assign o_busy    = (state != S_IDLE);
  assign accept    = i_valid & o_ready;
  assign word_done = accept & (byte_idx == 2'd3);
  assign full_hit  = word_done & ((word_count + 24'd1) == r_size);
  assign pending   = (byte_idx != 2'd0) | (word_count != 24'd0);
  assign timeout   = pending & ~accept & (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign trigger   = (accept & i_last) | i_flush | ~i_enable | timeout;

  // Occupancy as it will be after this edge, so a byte accepted alongside a flush is kept.
  assign idx_after   = byte_idx + {1'b0, accept};
  assign words_after = (word_count != 24'd0) | word_done;

  assign claim = (state == S_IDLE) & i_enable & (i_wr_rdy != 2'b00);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    claim_sel = 1'b0;
    case (i_wr_rdy)
      2'b10:   claim_sel = 1'b1;
      2'b11:   claim_sel = ~r_last_used;
      default: claim_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (claim) state_next = S_FILL;
      S_FILL: begin
        if (full_hit)
          state_next = S_RELEASE;
        else if (trigger) begin
          if (idx_after != 2'd0)
            state_next = S_PAD;
          else if (words_after)
            state_next = S_RELEASE;
        end
      end
      S_PAD:     state_next = S_RELEASE;
      S_RELEASE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wr_act    <= 2'b00;
      o_wr_stb    <= 1'b0;
      o_wr_data   <= 32'h0;
      byte_idx    <= 2'd0;
      partial     <= 24'h0;
      r_size      <= 24'h0;
      word_count  <= 24'h0;
      r_full      <= 1'b0;
      r_last_used <= 1'b1;
      idle_cnt    <= '0;
    end else begin
      o_wr_stb <= 1'b0;

      if ((state == S_FILL) && pending && !accept)
        idle_cnt <= idle_cnt + TW'(1);
      else
        idle_cnt <= '0;

      case (state)
        S_IDLE: begin
          if (claim) begin
            o_wr_act    <= claim_sel ? 2'b10 : 2'b01;
            r_last_used <= claim_sel;
            r_size      <= i_wr_size;
            word_count  <= 24'h0;
            byte_idx    <= 2'd0;
            partial     <= 24'h0;
            r_full      <= 1'b0;
          end
        end
        S_FILL: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            if (word_done) begin
              o_wr_data  <= {i_data, partial};
              o_wr_stb   <= 1'b1;
              word_count <= word_count + 24'd1;
              partial    <= 24'h0;
              if (full_hit) r_full <= 1'b1;
            end else begin
              case (byte_idx)
                2'd0:    partial[7:0]   <= i_data;
                2'd1:    partial[15:8]  <= i_data;
                default: partial[23:16] <= i_data;
              endcase
            end
          end
        end
        S_PAD: begin
          // Unwritten lanes of partial are already zero, giving the zero-padded word.
          o_wr_data  <= {8'h00, partial};
          o_wr_stb   <= 1'b1;
          word_count <= word_count + 24'd1;
          partial    <= 24'h0;
          byte_idx   <= 2'd0;
        end
        S_RELEASE: o_wr_act <= 2'b00;
        default: ;
      endcase
    end
  end

`ifdef STREAM_PACKER_BYTE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         o_byte_count <= 32'h0;
    else if (accept) o_byte_count <= o_byte_count + 32'd1;
  end
`else
  assign o_byte_count = 32'h0;
`endif

endmodule

// File: tb/tb_stream_ppfifo_packer.sv
// Directed self-checking bench for stream_ppfifo_packer: full buffer, end of packet,
// buffer availability, empty flush, idle timeout, last-on-word-boundary and async reset.
module tb_stream_ppfifo_packer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable, i_flush, i_valid, i_last;
  logic [7:0]  i_data;
  logic        o_ready;
  logic [1:0]  i_wr_rdy;
  logic [1:0]  o_wr_act;
  logic [23:0] i_wr_size;
  logic        o_wr_stb;
  logic [31:0] o_wr_data;
  logic        o_busy;
  logic [31:0] o_byte_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] stb_q[$];

  stream_ppfifo_packer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_enable(i_enable), .i_flush(i_flush),
    .i_data(i_data), .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready),
    .i_wr_rdy(i_wr_rdy), .o_wr_act(o_wr_act), .i_wr_size(i_wr_size),
    .o_wr_stb(o_wr_stb), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_byte_count(o_byte_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (!rst && o_wr_stb) stb_q.push_back(o_wr_data);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_flush = 1'b0; i_data = 8'h00;
    step();
    step();
    stb_q.delete();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    i_valid = 1'b1; i_data = d; i_last = last;
    while (!o_ready && n < 50) begin step(); n++; end
    if (n == 50) check("ready_timeout", o_ready, 1);
    step();
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  logic [31:0] exp_cnt;
  int c0, nq, d;

  initial begin
    i_enable = 1'b1; i_wr_rdy = 2'b11; i_wr_size = 24'd4;
    rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_flush = 1'b0; i_data = 8'h00;
    #1;
    check("rst_act", o_wr_act, 2'b00);
    check("rst_stb", o_wr_stb, 0);
    check("rst_ready", o_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_data", o_wr_data, 32'h0);
    check("rst_cnt", o_byte_count, 32'h0);

    // Full buffer of 4 words
    do_reset();
    step();
    check("full_claim_act", o_wr_act, 2'b01);
    check("full_claim_ready", o_ready, 1);
    c0 = cyc;
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b0);
    check("full_throughput", cyc - c0, 16);
    check("full_last_stb", o_wr_stb, 1);
    check("full_last_data", o_wr_data, 32'h100F0E0D);
    check("full_act_held", o_wr_act, 2'b01);
    check("full_not_ready", o_ready, 0);
    step();
    check("full_act_drop", o_wr_act, 2'b00);
    check("full_stb_drop", o_wr_stb, 0);
    step();
    check("full_next_claim", o_wr_act, 2'b10);
    check("full_nstb", stb_q.size(), 4);
    if (stb_q.size() == 4) begin
      check("full_w0", stb_q[0], 32'h04030201);
      check("full_w1", stb_q[1], 32'h08070605);
      check("full_w2", stb_q[2], 32'h0C0B0A09);
      check("full_w3", stb_q[3], 32'h100F0E0D);
    end

    // End of packet mid-word
    i_wr_size = 24'd16;
    do_reset();
    step();
    check("eop_claim", o_wr_act, 2'b01);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    send_byte(8'hA5, 1'b1);
    check("eop_pad_busy", o_busy, 1);
    check("eop_pad_ready", o_ready, 0);
    step();
    check("eop_pad_stb", o_wr_stb, 1);
    check("eop_pad_data", o_wr_data, 32'h0000A5A4);
    step();
    i_wr_rdy = 2'b00;
    check("eop_act_drop", o_wr_act, 2'b00);
    check("eop_nstb", stb_q.size(), 2);
    if (stb_q.size() >= 1) check("eop_w0", stb_q[0], 32'hA3A2A1A0);
`ifdef STREAM_PACKER_BYTE_COUNT_EN
    exp_cnt = 32'd6;
`else
    exp_cnt = 32'd0;
`endif
    check("eop_byte_count", o_byte_count, exp_cnt);

    // No buffer available
    i_valid = 1'b1; i_data = 8'h55;
    for (int i = 0; i < 4; i++) begin
      step();
      check("avail_ready", o_ready, 0);
      check("avail_act", o_wr_act, 2'b00);
    end
    i_valid = 1'b0;
    i_wr_rdy = 2'b10;
    step();
    check("avail_claim", o_wr_act, 2'b10);

    // Flush on an empty claim is ignored
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("eflush_act", o_wr_act, 2'b10);
    check("eflush_busy", o_busy, 1);
    check("eflush_ready", o_ready, 1);
    step();
    check("eflush_nostb", stb_q.size(), 2);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    check("eflush_word_stb", o_wr_stb, 1);
    check("eflush_word", o_wr_data, 32'hEFBEADDE);

    // Idle timeout flushes a partial word
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    nq = stb_q.size();
    c0 = cyc;
    for (int i = 0; i < 30 && !o_wr_stb; i++) step();
    d = cyc - c0;
    check("to_stb", o_wr_stb, 1);
    check("to_data", o_wr_data, 32'h00332211);
    check("to_latency", (d >= TO) && (d <= TO + 2), 1);
    i_wr_rdy = 2'b00;
    step();
    check("to_act_drop", o_wr_act, 2'b00);
    for (int i = 0; i < 20; i++) step();
    check("to_one_stb", stb_q.size() - nq, 1);

    // i_last on the 4th byte: one strobe, no pad
    i_wr_rdy = 2'b01;
    step();
    check("l4_claim", o_wr_act, 2'b01);
    send_byte(8'hC0, 1'b0);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b1);
    i_wr_rdy = 2'b00;
    check("l4_stb", o_wr_stb, 1);
    check("l4_data", o_wr_data, 32'hC3C2C1C0);
    step();
    check("l4_act_drop", o_wr_act, 2'b00);
    check("l4_no_pad_stb", o_wr_stb, 0);

    // Asynchronous reset mid-fill
    i_wr_rdy = 2'b11;
    step();
    check("ar_claim", o_wr_act, 2'b10);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
`ifdef STREAM_PACKER_BYTE_COUNT_EN
    exp_cnt = 32'd19;
`else
    exp_cnt = 32'd0;
`endif
    check("ar_cnt_before", o_byte_count, exp_cnt);
    #3;
    rst = 1'b1;
    #1;
    check("ar_act", o_wr_act, 2'b00);
    check("ar_stb", o_wr_stb, 0);
    check("ar_ready", o_ready, 0);
    check("ar_busy", o_busy, 0);
    check("ar_cnt", o_byte_count, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("ar_pref_buf0", o_wr_act, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
